// File: rtl/gray_scan_pkg.sv
// Shared definitions for the gray-code scan scheduler: FSM encodings,
// counter widths, the channel-index width helper and the gray decoder.
package gray_scan_pkg;

   // Scan slot FSM encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SAMPLE = 2'd1;
   localparam logic [1:0] ST_DECODE = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   // Stability counters hold 1..15
   localparam int unsigned STAB_W = 4;

   // Widest gray code the shared decoder accepts
   localparam int unsigned GMAX_W = 32;

   // Channel index width, never narrower than one bit
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // XOR-prefix from the MSB down. Narrower codes are zero-extended,
   // and leading zeros leave the prefix untouched.
   function automatic logic [GMAX_W-1:0] gray2bin(input logic [GMAX_W-1:0] g);
      logic [GMAX_W-1:0] b;
      b = '0;
      b[GMAX_W-1] = g[GMAX_W-1];
      for (int i = GMAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/module_gray_to_bin.sv
// Combinational gray-to-binary decoder shared by all scan channels.
//   gray_i : gray-coded input, WIDTH bits
//   bin_o  : binary equivalent, WIDTH bits
module module_gray_to_bin
   import gray_scan_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   assign bin_o = WIDTH'(gray2bin(GMAX_W'(gray_i)));

endmodule

// File: rtl/module_gray_scan_ctrl.sv
// Round-robin scan scheduler sharing one gray decoder across CHANNELS
// switch inputs, with per-channel debounce before committing a value.
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   en_i           : scan enable (gates the slot timer only)
//   gray_code_i    : packed gray inputs, channel k at [k*WIDTH +: WIDTH]
//   bin_code_o     : committed binary values, same packing
//   valid_o        : per-channel "committed at least once"
//   update_o       : one-cycle pulse when a channel output changes
//   update_ch_o    : channel index accompanying update_o
//   busy_o         : slot FSM not idle
module module_gray_scan_ctrl
   import gray_scan_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned SCAN_PERIOD  = 2700000,
   parameter int unsigned STABLE_COUNT = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic [CHANNELS*WIDTH-1:0]     gray_code_i,
   output logic [CHANNELS*WIDTH-1:0]     bin_code_o,
   output logic [CHANNELS-1:0]           valid_o,
   output logic                          update_o,
   output logic [ch_w(CHANNELS)-1:0]     update_ch_o,
   output logic                          busy_o
);

   localparam int unsigned CH_W  = ch_w(CHANNELS);
   localparam int unsigned TMR_W = $clog2(SCAN_PERIOD);
   localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(SCAN_PERIOD - 1);
   localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(STABLE_COUNT);
   localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CHANNELS - 1);

   logic [CHANNELS*WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0]          sync_ch [CHANNELS];

   logic [TMR_W-1:0] timer_q;
   logic             tick_q;

   logic [1:0]        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [WIDTH-1:0]  sample_q, sample_d;
   logic [WIDTH-1:0]  dec_q, dec_d, dec_c;
   logic [WIDTH-1:0]  cand_q [CHANNELS];
   logic [WIDTH-1:0]  cand_d [CHANNELS];
   logic [STAB_W-1:0] stab_q [CHANNELS];
   logic [STAB_W-1:0] stab_d [CHANNELS];
   logic [STAB_W-1:0] stab_nxt;
   logic [WIDTH-1:0]  bin_q  [CHANNELS];
   logic [WIDTH-1:0]  bin_d  [CHANNELS];
   logic [CHANNELS-1:0] valid_q, valid_d;
   logic              upd_q, upd_d;
   logic [CH_W-1:0]   upd_ch_q, upd_ch_d;
   logic              busy_q, busy_d;

   // Two-flop synchroniser, free running
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= gray_code_i;
         sync2_q <= sync1_q;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign sync_ch[k]                    = sync2_q[k*WIDTH +: WIDTH];
      assign bin_code_o[k*WIDTH +: WIDTH]  = bin_q[k];
   end

   // Slot timer: held at reload while disabled, one-cycle tick at zero
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         timer_q <= TMR_RELOAD;
         tick_q  <= 1'b0;
      end else if (!en_i) begin
         timer_q <= TMR_RELOAD;
         tick_q  <= 1'b0;
      end else if (timer_q == '0) begin
         timer_q <= TMR_RELOAD;
         tick_q  <= 1'b1;
      end else begin
         timer_q <= timer_q - TMR_W'(1);
         tick_q  <= 1'b0;
      end
   end

   module_gray_to_bin #(.WIDTH(WIDTH)) u_dec (
      .gray_i (sample_q),
      .bin_o  (dec_c)
   );

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state, datapath and outputs
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      sample_d = sample_q;
      dec_d    = dec_q;
      cand_d   = cand_q;
      stab_d   = stab_q;
      bin_d    = bin_q;
      valid_d  = valid_q;
      upd_d    = 1'b0;
      upd_ch_d = upd_ch_q;
      stab_nxt = '0;
      case (state_q)
         ST_IDLE: begin
            if (tick_q) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            sample_d = sync_ch[ch_q];
            state_d  = ST_DECODE;
         end
         ST_DECODE: begin
            dec_d   = dec_c;
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            // A new value restarts the debounce run; a repeat extends it
            if (dec_q != cand_q[ch_q]) begin
               cand_d[ch_q] = dec_q;
               stab_nxt     = STAB_W'(1);
            end else if (stab_q[ch_q] >= STAB_MAX) begin
               stab_nxt = STAB_MAX;
            end else begin
               stab_nxt = stab_q[ch_q] + STAB_W'(1);
            end
            stab_d[ch_q] = stab_nxt;
            if ((stab_nxt == STAB_MAX) &&
                ((dec_q != bin_q[ch_q]) || !valid_q[ch_q])) begin
               bin_d[ch_q]   = dec_q;
               valid_d[ch_q] = 1'b1;
               upd_d         = 1'b1;
               upd_ch_d      = ch_q;
            end
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ch_q     <= '0;
         sample_q <= '0;
         dec_q    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cand_q[i] <= '0;
            stab_q[i] <= '0;
            bin_q[i]  <= '0;
         end
         valid_q  <= '0;
         upd_q    <= 1'b0;
         upd_ch_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         ch_q     <= ch_d;
         sample_q <= sample_d;
         dec_q    <= dec_d;
         cand_q   <= cand_d;
         stab_q   <= stab_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         upd_q    <= upd_d;
         upd_ch_q <= upd_ch_d;
         busy_q   <= busy_d;
      end
   end

   assign valid_o     = valid_q;
   assign update_o    = upd_q;
   assign update_ch_o = upd_ch_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_module_gray_scan_ctrl.sv
// Randomised bench for the gray scan scheduler. Two instances share clock,
// reset and enable: index 0 debounces over two samples, index 1 commits on
// the first differing sample and has its channel 2 swept through all codes.
module tb_module_gray_scan_ctrl;

   localparam int unsigned W = 4;
   localparam int unsigned N = 4;
   localparam int unsigned P = 8;

   logic        clk, rst_n, en;
   logic [15:0] g     [2];
   logic [15:0] o_bin [2];
   logic [3:0]  o_val [2];
   logic        o_upd [2];
   logic [1:0]  o_uch [2];
   logic        o_busy[2];

   int checks, errors;

   module_gray_scan_ctrl #(.WIDTH(W), .CHANNELS(N), .SCAN_PERIOD(P), .STABLE_COUNT(2)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .en_i(en), .gray_code_i(g[0]),
      .bin_code_o(o_bin[0]), .valid_o(o_val[0]), .update_o(o_upd[0]),
      .update_ch_o(o_uch[0]), .busy_o(o_busy[0]));

   module_gray_scan_ctrl #(.WIDTH(W), .CHANNELS(N), .SCAN_PERIOD(P), .STABLE_COUNT(1)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .en_i(en), .gray_code_i(g[1]),
      .bin_code_o(o_bin[1]), .valid_o(o_val[1]), .update_o(o_upd[1]),
      .update_ch_o(o_uch[1]), .busy_o(o_busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: slot timing by edge counting, debounce by plain arithmetic
   int         sc [2] = '{2, 1};
   logic [3:0] m_cand [2][4];
   logic [3:0] m_bin  [2][4];
   int         m_stab [2][4];
   logic       m_val  [2][4];
   logic [3:0] cap    [2];
   logic       e_upd  [2];
   int         e_uch  [2];
   int  m_ch, run, age, slot_ch, last_ch, k, upd_cnt;
   bit  committed, rand_on, ch1_done;

   function automatic logic [3:0] g2b(input logic [3:0] gv);
      logic [3:0] b;
      b = '0;
      for (int s = 0; s < 4; s++) b ^= gv >> s;
      return b;
   endfunction

   function automatic logic [3:0] bin2gray(input int v);
      logic [3:0] x;
      x = 4'(v);
      return x ^ (x >> 1);
   endfunction

   function automatic logic [15:0] pack_bin(input int i);
      logic [15:0] v;
      for (int c = 0; c < 4; c++) v[c*4 +: 4] = m_bin[i][c];
      return v;
   endfunction

   function automatic logic [3:0] pack_val(input int i);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_val[i][c];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < 4; c++) begin
            m_cand[i][c] = '0; m_bin[i][c] = '0; m_stab[i][c] = 0; m_val[i][c] = 1'b0;
         end
         e_upd[i] = 1'b0; e_uch[i] = 0;
      end
      m_ch = 0; run = 0; age = -1;
   endtask

   task automatic model_edge();
      logic [3:0] d;
      committed = 1'b0;
      for (int i = 0; i < 2; i++) e_upd[i] = 1'b0;
      if (age >= 0) begin
         age++;
         if (age == 2)
            for (int i = 0; i < 2; i++) cap[i] = g[i][slot_ch*4 +: 4];
         if (age == 4) begin
            for (int i = 0; i < 2; i++) begin
               d = g2b(cap[i]);
               if (d != m_cand[i][slot_ch]) begin
                  m_cand[i][slot_ch] = d;
                  m_stab[i][slot_ch] = 1;
               end else if (m_stab[i][slot_ch] < sc[i]) begin
                  m_stab[i][slot_ch]++;
               end
               if (m_stab[i][slot_ch] == sc[i] &&
                   (d != m_bin[i][slot_ch] || !m_val[i][slot_ch])) begin
                  m_bin[i][slot_ch] = d;
                  m_val[i][slot_ch] = 1'b1;
                  e_upd[i] = 1'b1;
                  e_uch[i] = slot_ch;
               end
            end
            last_ch   = slot_ch;
            committed = 1'b1;
            m_ch      = (m_ch + 1) % N;
            age       = -1;
         end
      end
      if (en) begin
         run++;
         if (run % P == 0 && age < 0) begin
            age     = 0;
            slot_ch = m_ch;
         end
      end else begin
         run = 0;
      end
   endtask

   task automatic do_checks();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("update%0d", i), 32'(o_upd[i]), 32'(e_upd[i]));
         if (e_upd[i]) check_eq($sformatf("update_ch%0d", i), 32'(o_uch[i]), 32'(e_uch[i]));
         check_eq($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(age >= 1 && age <= 3));
         check_eq($sformatf("bin%0d", i), 32'(o_bin[i]), 32'(pack_bin(i)));
         check_eq($sformatf("valid%0d", i), 32'(o_val[i]), 32'(pack_val(i)));
      end
   endtask

   // New input values only right after a slot, well before the next sample
   task automatic stimulus();
      if (!committed) return;
      if (last_ch == 2) begin
         g[1][8 +: 4] = bin2gray(k % 16);
         k++;
      end
      if (last_ch == 1 && !ch1_done && !rand_on) begin
         g[0][4 +: 4] = 4'b0110;
         ch1_done = 1'b1;
      end
      if (rand_on) begin
         if ($urandom_range(0, 1) == 1) g[0][last_ch*4 +: 4] = 4'($urandom);
         if (last_ch != 2 && $urandom_range(0, 1) == 1) g[1][last_ch*4 +: 4] = 4'($urandom);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      do_checks();
      if (o_upd[0]) upd_cnt++;
      stimulus();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s_bin%0d", tag, i), 32'(o_bin[i]), 32'h0);
         check_eq($sformatf("%s_valid%0d", tag, i), 32'(o_val[i]), 32'h0);
         check_eq($sformatf("%s_upd%0d", tag, i), 32'(o_upd[i]), 32'h0);
         check_eq($sformatf("%s_uch%0d", tag, i), 32'(o_uch[i]), 32'h0);
         check_eq($sformatf("%s_busy%0d", tag, i), 32'(o_busy[i]), 32'h0);
      end
   endtask

   initial begin
      int n;
      checks = 0; errors = 0; upd_cnt = 0;
      rand_on = 1'b0; ch1_done = 1'b0; k = 1;
      rst_n = 1'b0; en = 1'b0;
      g[0] = {4'b0101, 4'b1100, 4'b0011, 4'b1000};
      g[1] = {4'($urandom), bin2gray(0), 4'($urandom), 4'($urandom)};
      model_reset();
      @(posedge clk); #1;
      check_all_zero("reset");
      #2 rst_n = 1'b1;

      // Directed start: ch0 debounce, ch1 changing before its second slot
      en = 1'b1;
      repeat (3 * N * P) step();
      check_eq("ch0_bin", 32'(o_bin[0][3:0]), 32'hF);
      check_eq("ch1_bin", 32'(o_bin[0][7:4]), 32'h4);

      // All channels held: no further updates on the debounced instance
      upd_cnt = 0;
      repeat (10 * N * P) step();
      check_eq("quiet_updates", 32'(upd_cnt), 32'h0);

      // Disabled window, then measure first slot after re-enable
      en = 1'b0;
      repeat (100) step();
      en = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!o_busy[0] && n < 20);
      check_eq("busy_latency", 32'(n), 32'd9);

      rand_on = 1'b1;
      repeat (600) step();

      // Asynchronous reset while in COMMIT
      n = 0;
      while (age != 3 && n < 40) begin
         step();
         n++;
      end
      check_eq("reach_commit", 32'(o_busy[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      #1 rst_n = 1'b1;
      repeat (8) step();
      repeat (300) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
